// File: rtl/id_pkg.sv
// Shared decode constants, ID/EX word layout and pc_src codes for the ID stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // alu_op reuses the R-type funct encoding; lui needs a pass-B op of its own
  localparam logic [5:0] ALU_PASSB = 6'h3F;

  localparam logic [3:0] PC_SRC_SEQ    = 4'd0;
  localparam logic [3:0] PC_SRC_BRANCH = 4'd1;
  localparam logic [3:0] PC_SRC_JUMP   = 4'd2;
  localparam logic [3:0] PC_SRC_JR     = 4'd3;

  localparam int CTRL_REG_WRITE  = 11;
  localparam int CTRL_MEM_READ   = 10;
  localparam int CTRL_MEM_WRITE  = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_LINK       = 6;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic [11:0] mk_ctrl(input logic rw, input logic mr, input logic mw,
                                          input logic m2r, input logic asrc, input logic link,
                                          input logic [5:0] op);
    return {rw, mr, mw, m2r, asrc, link, op};
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Stall and branch-operand forward select for the ID stage.
// ID_BRANCH_FWD_EN: forward EX/MEM ALU results into the branch comparator instead of stalling.
module id_hazard_unit
  import id_pkg::*;
(
  input  logic [1:0][4:0] src_i,     // [0] = rs, [1] = rt
  input  logic [1:0]      use_i,
  input  logic [1:0]      br_i,      // source feeds the branch/jr comparator
  input  logic [4:0]      idex_rd_i,
  input  logic            idex_reg_write_i,
  input  logic            idex_mem_read_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic            exmem_mem_read_i,
  output logic            stall_o,
  output logic [1:0]      fwd_o
);

  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (src != 5'd0) && (dst == src);
  endfunction

  always_comb begin
    stall_o = 1'b0;
    fwd_o   = '0;
    for (int s = 0; s < 2; s++) begin
      if (use_i[s] && idex_mem_read_i && hit(idex_rd_i, src_i[s]))
        stall_o = 1'b1;
      if (br_i[s] && idex_reg_write_i && hit(idex_rd_i, src_i[s]))
        stall_o = 1'b1;
      if (br_i[s] && exmem_mem_read_i && hit(exmem_rd_i, src_i[s]))
        stall_o = 1'b1;
      if (br_i[s] && exmem_reg_write_i && !exmem_mem_read_i && hit(exmem_rd_i, src_i[s])) begin
`ifdef ID_BRANCH_FWD_EN
        fwd_o[s] = 1'b1;
`else
        stall_o = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decode, branch/jump resolution, hazard stalls, ID/EX register, stall counter.
// ID_BRANCH_FWD_EN (see id_hazard_unit) selects comparator forwarding over an extra stall.
module id_stage
  import id_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            if_id,
  output logic [4:0]             rs_addr,
  output logic [4:0]             rt_addr,
  input  logic [31:0]            rs_data,
  input  logic [31:0]            rt_data,
  input  logic [4:0]             exmem_rd,
  input  logic                   exmem_reg_write,
  input  logic                   exmem_mem_read,
  input  logic [31:0]            exmem_alu_result,
  input  logic                   id_flush,
  output logic [3:0]             pc_src,
  output logic [31:0]            branch_address,
  output logic [31:0]            jump_address,
  output logic [31:0]            jr_address,
  output logic                   if_flush,
  output logic                   if_pause,
  output logic [11:0]            id_ex_ctrl,
  output logic [31:0]            id_ex_rs_data,
  output logic [31:0]            id_ex_rt_data,
  output logic [31:0]            id_ex_imm,
  output logic [4:0]             id_ex_rd,
  output logic [31:0]            id_ex_pc_plus4,
  output logic                   undefined_inst,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [31:0] instr, pc4, imm_sext;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;

  assign instr    = if_id[31:0];
  assign pc4      = if_id[63:32];
  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign rs_addr  = rs;
  assign rt_addr  = rt;

  logic [11:0] dec_ctrl;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        use_rs, use_rt, is_br, is_bne, is_j, is_jr, undef, is_nop;

  always_comb begin
    dec_ctrl = '0;
    dec_rd   = '0;
    dec_imm  = imm_sext;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_br    = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    undef    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: begin
            dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, funct);
            dec_rd   = rd;
            use_rt   = 1'b1;
          end
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, funct);
            dec_rd   = rd;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
          end
          F_JR: begin
            is_jr  = 1'b1;
            use_rs = 1'b1;
          end
          F_JALR: begin
            dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ADD);
            dec_rd   = rd;
            is_jr    = 1'b1;
            use_rs   = 1'b1;
          end
          default: undef = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F_ADD);
        dec_rd   = rt;
        use_rs   = 1'b1;
      end
      OP_SLTI: begin
        dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F_SLT);
        dec_rd   = rt;
        use_rs   = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (op == OP_ANDI) ? F_AND : F_OR);
        dec_rd   = rt;
        dec_imm  = {16'h0, instr[15:0]};
        use_rs   = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_PASSB);
        dec_rd   = rt;
        dec_imm  = {instr[15:0], 16'h0};
      end
      OP_LW: begin
        dec_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, F_ADD);
        dec_rd   = rt;
        use_rs   = 1'b1;
      end
      OP_SW: begin
        dec_ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F_ADD);
        use_rs   = 1'b1;
        use_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        is_br  = 1'b1;
        is_bne = (op == OP_BNE);
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        dec_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ADD);
        dec_rd   = 5'd31;
        is_j     = 1'b1;
      end
      default: undef = 1'b1;
    endcase
    // a flushed fetch slot arrives as all zeros; keep it out of the hazard logic
    is_nop = (instr == 32'h0);
    if (is_nop) begin
      use_rs = 1'b0;
      use_rt = 1'b0;
    end
  end

  id_ex_t idex_q, idex_d;
  logic   undef_q, undef_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic   hz_stall;
  logic [1:0] fwd;

  id_hazard_unit u_hz (
    .src_i            ({rt, rs}),
    .use_i            ({use_rt, use_rs}),
    .br_i             ({is_br, is_br | is_jr}),
    .idex_rd_i        (idex_q.rd),
    .idex_reg_write_i (idex_q.ctrl[CTRL_REG_WRITE]),
    .idex_mem_read_i  (idex_q.ctrl[CTRL_MEM_READ]),
    .exmem_rd_i       (exmem_rd),
    .exmem_reg_write_i(exmem_reg_write),
    .exmem_mem_read_i (exmem_mem_read),
    .stall_o          (hz_stall),
    .fwd_o            (fwd)
  );

  logic [31:0] rs_val, rt_val;
  logic        taken, kill;

  assign rs_val = fwd[0] ? exmem_alu_result : rs_data;
  assign rt_val = fwd[1] ? exmem_alu_result : rt_data;
  assign taken  = is_br && ((rs_val == rt_val) ^ is_bne);
  // reset gates the combinational fetch controls so a stall releases at once
  assign kill   = id_flush | reset;

  assign branch_address = {pc4[31], pc4[30:0] + {imm_sext[28:0], 2'b00}};
  assign jump_address   = {pc4[31:28], instr[25:0], 2'b00};
  assign jr_address     = rs_val;
  assign if_pause       = hz_stall & ~kill;

  always_comb begin
    pc_src = PC_SRC_SEQ;
    if (!kill && !hz_stall) begin
      if (taken)      pc_src = PC_SRC_BRANCH;
      else if (is_j)  pc_src = PC_SRC_JUMP;
      else if (is_jr) pc_src = PC_SRC_JR;
    end
  end
  assign if_flush = (pc_src != PC_SRC_SEQ);

  always_comb begin
    idex_d = '{ctrl: dec_ctrl, rd: dec_rd, imm: dec_imm, pc_plus4: pc4,
               rs_data: rs_data, rt_data: rt_data};
    if (id_flush || hz_stall || undef || is_nop)
      idex_d = ID_EX_BUBBLE;
    undef_d = undef & ~id_flush;
    cnt_d   = cnt_q;
    if (if_pause && (cnt_q != {STALL_CNT_W{1'b1}}))
      cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= ID_EX_BUBBLE;
      undef_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      undef_q <= undef_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_ex_ctrl     = idex_q.ctrl;
  assign id_ex_rd       = idex_q.rd;
  assign id_ex_imm      = idex_q.imm;
  assign id_ex_pc_plus4 = idex_q.pc_plus4;
  assign id_ex_rs_data  = idex_q.rs_data;
  assign id_ex_rt_data  = idex_q.rt_data;
  assign undefined_inst = undef_q;
  assign stall_count    = cnt_q;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage and hazard controller that consumes the 64-bit IF/ID word (`{pc_plus4, instr}`) produced by the fetch stage. It decodes the instruction, reads operands, and resolves branches, jumps and jr in ID. It drives the fetch stage's `pc_src`, target addresses, `if_flush` and `if_pause`, and registers the ID/EX pipeline word. A load-use and branch-operand hazard unit inserts bubbles, and a counter records stall cycles.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the saturating stall counter.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `if_id` in 64: `[63:32]` pc_plus4 (bit 31 = supervisor bit), `[31:0]` instr.
- `rs_addr`, `rt_addr` out 5: register-file read addresses, `instr[25:21]` and `instr[20:16]`.
- `rs_data`, `rt_data` in 32: combinational register-file read data.
- `exmem_rd` in 5, `exmem_reg_write` in 1, `exmem_mem_read` in 1, `exmem_alu_result` in 32: EX/MEM destination status.
- `id_flush` in 1: exception/interrupt squash of ID.
- `pc_src` out 4: 0 = seq, 1 = branch, 2 = jump, 3 = jr.
- `branch_address`, `jump_address`, `jr_address` out 32: fetch targets.
- `if_flush` out 1: squash the slot being fetched.
- `if_pause` out 1: hold PC and IF/ID.
- `id_ex_ctrl` out 12, `id_ex_rs_data` out 32, `id_ex_rt_data` out 32, `id_ex_imm` out 32, `id_ex_rd` out 5, `id_ex_pc_plus4` out 32: registered ID/EX word.
- `undefined_inst` out 1: registered one-cycle pulse for an unknown opcode/funct.
- `stall_count` out `STALL_CNT_W`.

## Operation
- Decode covers R-type ALU, `addi/andi/ori/slti/lui`, `lw/sw`, `beq/bne`, `j/jal`, `jr/jalr`.
- `id_ex_ctrl` bits: reg_write, mem_read, mem_write, mem_to_reg, alu_src, link, alu_op[5:0].
- Destination register: rd for R-type, rt for I-type, 31 for jal.
- Immediates: sign-extended except `andi/ori` (zero-extended) and `lui` (imm<<16).
- `branch_address` = `{pc_plus4[31], pc_plus4[30:0] + (sext(imm)<<2)[30:0]}`. The supervisor bit is never changed by a branch.
- `jump_address` = `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- `jr_address` = resolved rs value.
- Branch compare uses the resolved rs/rt values.
- Taken branch, j/jal or jr/jalr (no stall): `pc_src` = target code and `if_flush` = 1. There is no delay slot.
- Otherwise `pc_src` = 0 and `if_flush` = 0.
- Hazard stall (`if_pause` = 1) when any of the following holds:
  - Load-use: ID/EX mem_read, `id_ex_rd` != 0, and `id_ex_rd` equals a source register the current instruction uses.
  - Branch/jr source in flight in EX: ID/EX reg_write, `id_ex_rd` != 0, and `id_ex_rd` matches the source.
  - Branch/jr source pending from a load: `exmem_mem_read` with `exmem_rd` matching the source.
- During a stall:
  - ID/EX loads a bubble (all fields zero).
  - `pc_src` = 0, `if_flush` = 0.
  - `stall_count` increments, saturating at all-ones.
- `id_flush` = 1: ID/EX loads a bubble, `pc_src` = 0, `if_flush` = 0, `if_pause` = 0, and `undefined_inst` is suppressed. `id_flush` overrides a stall.
- All-zero instr (a flushed slot) decodes as a nop bubble and never stalls.

## Timing
- `pc_src`, addresses, `if_flush`, `if_pause` and `rs_addr/rt_addr` are combinational from `if_id` and the current ID/EX state. The fetch stage samples them at the same edge.
- The ID/EX word, `undefined_inst` and `stall_count` update on the rising edge. Latency is one cycle.
- Load-use costs 1 stall cycle.
- A branch after an ALU producer costs 1 stall cycle.
- A branch after a load costs 2 stall cycles: EX, then EX/MEM.
- Reset: every ID/EX field = 0, `undefined_inst` = 0, `stall_count` = 0. Reset mid-stall releases `if_pause` immediately.
- A register address of 0 never matches a hazard.

## Configuration
- `ID_BRANCH_FWD_EN` defined: the branch/jr comparator takes `exmem_alu_result` when `exmem_reg_write & !exmem_mem_read & exmem_rd == src & src != 0`.
- `ID_BRANCH_FWD_EN` undefined: that same condition adds one further stall cycle instead, and `exmem_alu_result` is unused.

## Structure
- Shared package `id_pkg`:
  - opcode/funct constants
  - `PC_SRC_SEQ/BRANCH/JUMP/JR`
  - `id_ex_ctrl` bit indices
  - bubble constant
- Sub-module `id_hazard_unit`: combinational stall and forward-select logic. The decoder, target adders and ID/EX register stay in `id_stage`.

## Test plan
- `beq $1,$1,+4` at pc_plus4 0x8000_0104, no hazards → `pc_src` = 1, `branch_address` = 0x8000_0114, `if_flush` = 1.
- `lw $2,0($3)` followed by `add $4,$2,$5` → `if_pause` = 1 for one cycle, ID/EX = bubble, then `add` issues; `stall_count` = 1.
- `lw $2` followed by `bne $2,$0` → two stall cycles, then correct resolution; `stall_count` = 2.
- `add $6` followed by `jr $6` with the add in EX/MEM, result 0x0000_3000 → with the macro, `jr_address` = 0x0000_3000 and no stall in that cycle; without the macro, one extra stall.
- `jal 0x0100000` at pc_plus4 0x0000_2004 → `jump_address` = 0x0040_0000, `id_ex_rd` = 31, link = 1, `if_flush` = 1.
- Opcode 0x3F with `id_flush` low → `undefined_inst` pulses for one cycle. `id_flush` asserted during a load-use stall → bubble, `if_pause` = 0. Reset asserted mid-stall → all outputs return to their reset values.
